// File: rtl/axi_stream_beat_gen.sv
// axi_stream_beat_gen
//   Turns one command (len, seed, incr) into a stream burst of len+1 beats.
//   Beat k carries seed + k*incr, wrapping modulo 2^DATA_WIDTH.
//   Every output except o_busy comes straight from a flop.
//
// Ports
//   i_axi_aclk     clock; all state changes on its rising edge
//   i_axi_areset   asynchronous, active-high reset
//   i_cmd_valid    command request
//   o_cmd_ready    command accept; high only while idle
//   i_cmd_len      burst length minus one
//   i_cmd_seed     payload of the first beat
//   i_cmd_incr     payload step between beats
//   o_wr_valid     stream beat valid
//   i_wr_ready     downstream ready
//   o_wr_data      stream payload
//   o_wr_last      marks the final beat of the burst
//   o_busy         burst in progress
//   o_done         one-cycle pulse after the final beat handshake
//   o_beat_count   beats transferred in the current or most recent burst
module axi_stream_beat_gen #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   i_axi_aclk,
   input  logic                   i_axi_areset,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [COUNT_WIDTH-1:0] i_cmd_len,
   input  logic [DATA_WIDTH-1:0]  i_cmd_seed,
   input  logic [DATA_WIDTH-1:0]  i_cmd_incr,
   output logic                   o_wr_valid,
   input  logic                   i_wr_ready,
   output logic [DATA_WIDTH-1:0]  o_wr_data,
   output logic                   o_wr_last,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [COUNT_WIDTH:0]   o_beat_count
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   localparam logic [COUNT_WIDTH-1:0] IDX_ONE = 1;
   localparam logic [COUNT_WIDTH:0]   CNT_ONE = 1;

   state_t                 state_q, state_nxt;
   logic [COUNT_WIDTH-1:0] len_q;
   logic [COUNT_WIDTH-1:0] idx_q;
   logic [COUNT_WIDTH-1:0] idx_inc;
   logic [DATA_WIDTH-1:0]  incr_q;
   logic                   cmd_xfer;
   logic                   wr_xfer;

   assign cmd_xfer = i_cmd_valid && o_cmd_ready;
   assign wr_xfer  = o_wr_valid && i_wr_ready;
   assign idx_inc  = idx_q + IDX_ONE;
   assign o_busy   = (state_q == SEND);

   // State register
   always_ff @(posedge i_axi_aclk or posedge i_axi_areset) begin
      if (i_axi_areset) state_q <= IDLE;
      else              state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: if (cmd_xfer)              state_nxt = SEND;
         SEND: if (wr_xfer && o_wr_last)  state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge i_axi_aclk or posedge i_axi_areset) begin
      if (i_axi_areset) begin
         o_cmd_ready  <= 1'b0;
         o_wr_valid   <= 1'b0;
         o_wr_data    <= '0;
         o_wr_last    <= 1'b0;
         o_done       <= 1'b0;
         o_beat_count <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         incr_q       <= '0;
      end else begin
         // Ready tracks the state we are entering, so it rises in the same
         // cycle as o_done and on the first edge after reset release.
         o_cmd_ready <= (state_nxt == IDLE);
         o_done      <= 1'b0;
         if (cmd_xfer) begin
            len_q        <= i_cmd_len;
            incr_q       <= i_cmd_incr;
            idx_q        <= '0;
            o_wr_valid   <= 1'b1;
            o_wr_data    <= i_cmd_seed;
            o_wr_last    <= (i_cmd_len == '0);
            o_beat_count <= '0;
         end else if (wr_xfer) begin
            o_beat_count <= o_beat_count + CNT_ONE;
            if (o_wr_last) begin
               o_wr_valid <= 1'b0;
               o_wr_last  <= 1'b0;
               o_done     <= 1'b1;
            end else begin
               // idx_q < len_q here, so idx_inc never wraps.
               idx_q     <= idx_inc;
               o_wr_data <= o_wr_data + incr_q;
               o_wr_last <= (idx_inc == len_q);
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_beat_gen.sv
module tb_axi_stream_beat_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_len;
   logic [31:0] cmd_seed;
   logic [31:0] cmd_incr;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic        wr_last;
   logic        busy;
   logic        done;
   logic [8:0]  beat_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_stream_beat_gen #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) dut (
      .i_axi_aclk   (clk),
      .i_axi_areset (rst),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_len    (cmd_len),
      .i_cmd_seed   (cmd_seed),
      .i_cmd_incr   (cmd_incr),
      .o_wr_valid   (wr_valid),
      .i_wr_ready   (wr_ready),
      .o_wr_data    (wr_data),
      .o_wr_last    (wr_last),
      .o_busy       (busy),
      .o_done       (done),
      .o_beat_count (beat_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle before driving/sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check one visible beat: valid, data, last, beat count.
   task automatic chk_beat(input string tag, input logic [31:0] d, input logic l, input logic [8:0] c);
      chk({tag, ".valid"}, {63'd0, wr_valid}, 64'd1);
      chk({tag, ".data"},  {32'd0, wr_data},  {32'd0, d});
      chk({tag, ".last"},  {63'd0, wr_last},  {63'd0, l});
      chk({tag, ".cnt"},   {55'd0, beat_count}, {55'd0, c});
      chk({tag, ".busy"},  {63'd0, busy},     64'd1);
      chk({tag, ".rdy"},   {63'd0, cmd_ready}, 64'd0);
   endtask

   // Cycle after the final handshake.
   task automatic chk_end(input string tag, input logic [8:0] c);
      chk({tag, ".valid"}, {63'd0, wr_valid}, 64'd0);
      chk({tag, ".last"},  {63'd0, wr_last},  64'd0);
      chk({tag, ".done"},  {63'd0, done},     64'd1);
      chk({tag, ".rdy"},   {63'd0, cmd_ready}, 64'd1);
      chk({tag, ".busy"},  {63'd0, busy},     64'd0);
      chk({tag, ".cnt"},   {55'd0, beat_count}, {55'd0, c});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".rdy"},   {63'd0, cmd_ready}, 64'd0);
      chk({tag, ".valid"}, {63'd0, wr_valid}, 64'd0);
      chk({tag, ".last"},  {63'd0, wr_last},  64'd0);
      chk({tag, ".data"},  {32'd0, wr_data},  64'd0);
      chk({tag, ".busy"},  {63'd0, busy},     64'd0);
      chk({tag, ".done"},  {63'd0, done},     64'd0);
      chk({tag, ".cnt"},   {55'd0, beat_count}, 64'd0);
   endtask

   task automatic issue(input logic [7:0] l, input logic [31:0] s, input logic [31:0] i);
      cmd_valid = 1'b1;
      cmd_len   = l;
      cmd_seed  = s;
      cmd_incr  = i;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0; cmd_incr = '0; wr_ready = 1'b1;
      #1;
      chk_zero("rst0");
      tick(); tick();
      chk_zero("rst_hold");
      rst = 1'b0;
      #1;
      chk("rst_rel.rdy_pre", {63'd0, cmd_ready}, 64'd0);
      tick();
      chk("rst_rel.rdy", {63'd0, cmd_ready}, 64'd1);

      // len=3 seed=0x10 incr=4, back-to-back
      issue(8'd3, 32'h10, 32'h4);
      chk_beat("b4.0", 32'h10, 1'b0, 9'd0); tick();
      chk_beat("b4.1", 32'h14, 1'b0, 9'd1); tick();
      chk_beat("b4.2", 32'h18, 1'b0, 9'd2); tick();
      chk_beat("b4.3", 32'h1C, 1'b1, 9'd3); tick();
      chk_end("b4.end", 9'd4);
      tick();
      chk("b4.done_pulse", {63'd0, done}, 64'd0);
      chk("b4.cnt_hold", {55'd0, beat_count}, 64'd4);

      // single beat
      issue(8'd0, 32'hAB, 32'h1);
      chk_beat("b1.0", 32'hAB, 1'b1, 9'd0); tick();
      chk_end("b1.end", 9'd1);
      tick();

      // stall on beat 1 for 5 cycles
      issue(8'd2, 32'h100, 32'h10);
      chk_beat("st.0", 32'h100, 1'b0, 9'd0); tick();
      chk_beat("st.1", 32'h110, 1'b0, 9'd1);
      wr_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_beat("st.hold", 32'h110, 1'b0, 9'd1);
      end
      wr_ready = 1'b1;
      tick();
      chk_beat("st.2", 32'h120, 1'b1, 9'd2); tick();
      chk_end("st.end", 9'd3);
      tick();

      // payload wrap
      issue(8'd3, 32'hFFFF_FFFE, 32'h1);
      chk_beat("wr.0", 32'hFFFF_FFFE, 1'b0, 9'd0); tick();
      chk_beat("wr.1", 32'hFFFF_FFFF, 1'b0, 9'd1); tick();
      chk_beat("wr.2", 32'h0,         1'b0, 9'd2); tick();
      chk_beat("wr.3", 32'h1,         1'b1, 9'd3); tick();
      chk_end("wr.end", 9'd4);
      tick();

      // reset mid-burst
      issue(8'd7, 32'h500, 32'h1);
      chk_beat("mr.0", 32'h500, 1'b0, 9'd0); tick();
      chk_beat("mr.1", 32'h501, 1'b0, 9'd1);
      rst = 1'b1;
      #1;
      chk_zero("mr.async");
      tick();
      chk_zero("mr.hold");
      rst = 1'b0;
      tick();
      chk("mr.rdy", {63'd0, cmd_ready}, 64'd1);
      chk("mr.nodone", {63'd0, done}, 64'd0);
      chk("mr.novalid", {63'd0, wr_valid}, 64'd0);
      issue(8'd1, 32'h77, 32'h2);
      chk_beat("mr.n0", 32'h77, 1'b0, 9'd0); tick();
      chk_beat("mr.n1", 32'h79, 1'b1, 9'd1); tick();
      chk_end("mr.end", 9'd2);
      tick();

      // command held valid during SEND
      cmd_valid = 1'b1; cmd_len = 8'd1; cmd_seed = 32'h20; cmd_incr = 32'h1;
      tick();
      cmd_seed = 32'h40;
      chk_beat("hv.0", 32'h20, 1'b0, 9'd0); tick();
      chk_beat("hv.1", 32'h21, 1'b1, 9'd1); tick();
      chk_end("hv.end", 9'd2);
      tick();
      cmd_valid = 1'b0;
      chk_beat("hv.n0", 32'h40, 1'b0, 9'd0); tick();
      chk_beat("hv.n1", 32'h41, 1'b1, 9'd1); tick();
      chk_end("hv.nend", 9'd2);
      tick(); tick();
      chk("hv.idle_valid", {63'd0, wr_valid}, 64'd0);
      chk("hv.idle_cnt", {55'd0, beat_count}, 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
